// File: rtl/i2c_sched_pkg.sv
// Shared types for the I2C engine scheduler: FSM states, requester IDs and
// the request word handed to the engine.
package i2c_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_BUSY  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4,
    ST_GAP   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    OWN_INIT = 2'd0,
    OWN_HOST = 2'd1,
    OWN_POLL = 2'd2
  } owner_e;

  localparam logic [31:0] TMP_PTR = 32'h0;

  // Engine-domain inputs that cross into sys_clk: ready and rd_valid.
  localparam int SYNC_W     = 2;
  localparam int SYNC_READY = 0;
  localparam int SYNC_RDV   = 1;

  typedef struct packed {
    logic        wr_rd;
    logic        eprom;
    logic [31:0] reg_in;
  } eng_req_t;

  // Poll reads the temperature pointer; init writes the config word.
  function automatic eng_req_t make_req(owner_e own, eng_req_t host_r,
                                        logic [31:0] cfg_word);
    eng_req_t r;
    r = '{wr_rd: 1'b1, eprom: 1'b0, reg_in: TMP_PTR};
    case (own)
      OWN_INIT: r = '{wr_rd: 1'b0, eprom: 1'b0, reg_in: cfg_word};
      OWN_HOST: r = host_r;
      default:  ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/i2c_sched_sync.sv
// Multi-flop synchronizer for one slow-domain level, with edge detect on the
// synchronized value.
module i2c_sched_sync #(
  parameter int STAGES = 2
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES:0] pipe;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) pipe <= '0;
    else        pipe <= {pipe[STAGES-1:0], d};
  end

  // pipe[STAGES] is the previous synchronized sample
  assign q    = pipe[STAGES-1];
  assign rise =  pipe[STAGES-1] & ~pipe[STAGES];
  assign fall = ~pipe[STAGES-1] &  pipe[STAGES];

endmodule

// File: rtl/i2c_bus_sched.sv
// Fixed-priority scheduler for the shared I2C engine: init > host > poll,
// with start/ready handshake sequencing, watchdog and result routing.
module i2c_bus_sched
  import i2c_sched_pkg::*;
#(
  parameter logic [31:0] CFG_WORD    = 32'h0101_0160,
  parameter logic [19:0] TIMEOUT_CYC = 20'd400000,
  parameter logic [11:0] GAP_CYC     = 12'd2000
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        init_req,
  input  logic        host_req,
  input  logic        host_wr_rd,
  input  logic        host_eprom,
  input  logic [31:0] host_wdata,
  output logic        host_busy,
  output logic        host_done,
  output logic        host_err,
  output logic [15:0] host_rdata,
  output logic        host_drop,
  input  logic        poll_tick,
  input  logic        poll_inhibit,
  output logic [15:0] tmp_data,
  output logic        tmp_valid,
  output logic        eng_start,
  output logic        eng_wr_rd,
  output logic        eng_eprom,
  output logic [31:0] eng_reg_in,
  input  logic        eng_ready,
  input  logic        eng_rd_valid,
  input  logic [15:0] eng_rd_data
);

  state_e      state, state_nx;
  owner_e      owner, grant_own;
  eng_req_t    eng_q, host_q;
  logic        init_p, host_p, poll_p, any_p, grant;
  logic        got_data;
  logic [15:0] rd_buf;
  logic [19:0] cnt;
  logic        wd_exp, gap_end;
  logic        dlv_host, dlv_err, dlv_tmp;

  // ---- engine-domain synchronizers ----
  logic [SYNC_W-1:0] async_in, sync_q, sync_rise, sync_fall;
  logic              ready_s, ready_rise, ready_fall, rdv_rise;
  logic              unused_sync;

  assign async_in = {eng_rd_valid, eng_ready};

  for (genvar g = 0; g < SYNC_W; g++) begin : g_sync
    i2c_sched_sync #(.STAGES(2)) u_sync (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .d       (async_in[g]),
      .q       (sync_q[g]),
      .rise    (sync_rise[g]),
      .fall    (sync_fall[g])
    );
  end

  assign ready_s     = sync_q[SYNC_READY];
  assign ready_rise  = sync_rise[SYNC_READY];
  assign ready_fall  = sync_fall[SYNC_READY];
  assign rdv_rise    = sync_rise[SYNC_RDV];
  assign unused_sync = &{1'b0, sync_q[SYNC_RDV], sync_fall[SYNC_RDV]};

  // ---- arbitration ----
  always_comb begin
    grant_own = OWN_POLL;
    if (init_p)      grant_own = OWN_INIT;
    else if (host_p) grant_own = OWN_HOST;
  end

  assign any_p     = init_p | host_p | poll_p;
  assign grant     = (state == ST_IDLE) & any_p & ready_s;
  assign host_busy = host_p | ((owner == OWN_HOST) & (state != ST_IDLE));

  // A new request in the grant cycle wins, so the source stays queued.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      init_p <= 1'b0;
      host_p <= 1'b0;
      poll_p <= 1'b0;
      host_q <= '0;
    end else begin
      if (init_req)                              init_p <= 1'b1;
      else if (grant && grant_own == OWN_INIT)   init_p <= 1'b0;

      if (host_req && !host_busy) begin
        host_p <= 1'b1;
        host_q <= '{wr_rd: host_wr_rd, eprom: host_eprom, reg_in: host_wdata};
      end else if (grant && grant_own == OWN_HOST) begin
        host_p <= 1'b0;
      end

      if (poll_tick && !poll_inhibit)            poll_p <= 1'b1;
      else if (grant && grant_own == OWN_POLL)   poll_p <= 1'b0;
    end
  end

  // ---- FSM: state register ----
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Shared counter: watchdog in ISSUE/BUSY, gap length in GAP.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (state_nx != state) cnt <= '0;
    else if (state != ST_IDLE)  cnt <= cnt + 20'd1;
  end

  assign wd_exp  = ((state == ST_ISSUE) || (state == ST_BUSY)) &&
                   (cnt == TIMEOUT_CYC - 20'd1);
  assign gap_end = (cnt == {8'd0, GAP_CYC} - 20'd1);

  // ---- FSM: next state ----
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (grant) state_nx = ST_ISSUE;
      ST_ISSUE: begin
        if (ready_fall)  state_nx = ST_BUSY;
        else if (wd_exp) state_nx = ST_ERR;
      end
      ST_BUSY: begin
        if (ready_rise)  state_nx = ST_DONE;
        else if (wd_exp) state_nx = ST_ERR;
      end
      ST_DONE:  state_nx = ST_GAP;
      ST_ERR:   state_nx = ST_GAP;
      ST_GAP:   if (gap_end) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    eng_start = 1'b0;
    dlv_host  = 1'b0;
    dlv_err   = 1'b0;
    dlv_tmp   = 1'b0;
    case (state)
      ST_ISSUE: eng_start = 1'b1;
      ST_DONE: begin
        dlv_host = (owner == OWN_HOST);
        dlv_err  = eng_q.wr_rd & ~got_data;
        dlv_tmp  = (owner == OWN_POLL) & eng_q.wr_rd & got_data;
      end
      ST_ERR: begin
        dlv_host = (owner == OWN_HOST);
        dlv_err  = 1'b1;
      end
      default: ;
    endcase
  end

  // ---- transaction datapath ----
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      owner    <= OWN_INIT;
      eng_q    <= '0;
      got_data <= 1'b0;
      rd_buf   <= '0;
    end else if (grant) begin
      owner    <= grant_own;
      eng_q    <= make_req(grant_own, host_q, CFG_WORD);
      got_data <= 1'b0;
    end else if (state == ST_BUSY && rdv_rise) begin
      // rd_data is held stable while rd_valid is high, so sampling late is safe
      rd_buf   <= eng_rd_data;
      got_data <= 1'b1;
    end
  end

  assign eng_wr_rd  = eng_q.wr_rd;
  assign eng_eprom  = eng_q.eprom;
  assign eng_reg_in = eng_q.reg_in;

  // ---- result delivery ----
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      host_done  <= 1'b0;
      host_err   <= 1'b0;
      host_rdata <= '0;
      host_drop  <= 1'b0;
      tmp_valid  <= 1'b0;
      tmp_data   <= '0;
    end else begin
      host_done  <= dlv_host;
      host_err   <= dlv_host & dlv_err;
      host_rdata <= (dlv_host && !dlv_err && eng_q.wr_rd) ? rd_buf : '0;
      host_drop  <= host_req & host_busy;
      tmp_valid  <= dlv_tmp;
      if (dlv_tmp) tmp_data <= rd_buf;
    end
  end

endmodule
